// File: rtl/tx_frame_streamer.sv
// Streams a frame held in an internal byte buffer out of an AXI-stream source, one byte per beat.
// Define TX_FRAME_STREAMER_PAD_EN to zero-pad short frames up to MIN_FRAME bytes.
module tx_frame_streamer #(
    parameter int ADDR_WIDTH = 11,
    parameter int MIN_FRAME  = 60
) (
    input  logic                  clk_int,
    input  logic                  rst_int,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [7:0]            wr_data,
    input  logic [ADDR_WIDTH:0]   tx_len,
    input  logic                  tx_start,
    input  logic                  tx_abort,
    output logic                  tx_busy,
    output logic                  tx_done,
    output logic [7:0]            tx_axis_tdata,
    output logic                  tx_axis_tvalid,
    output logic                  tx_axis_tlast,
    output logic                  tx_axis_tuser,
    input  logic                  tx_axis_tready
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] MAX_LEN = (ADDR_WIDTH+1)'(DEPTH);
`ifdef TX_FRAME_STREAMER_PAD_EN
    localparam bit PAD_ENABLED = 1'b1;
`else
    localparam bit PAD_ENABLED = 1'b0;
`endif
    localparam logic [ADDR_WIDTH:0] PAD_MIN = PAD_ENABLED ? (ADDR_WIDTH+1)'(MIN_FRAME) : '0;

    typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_t;

    state_t                state_reg, state_next;
    logic [7:0]            mem [0:DEPTH-1];
    logic [7:0]            rd_data_reg;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [ADDR_WIDTH:0]   len_reg;
    logic [ADDR_WIDTH:0]   idx_reg;
    logic [ADDR_WIDTH:0]   last_idx;
    logic                  abort_pend_reg;
    logic                  abort_beat_reg;
    logic                  start_ok;
    logic                  beat_fire;
    logic                  is_last;
    logic                  abort_ok;

    // Buffer: writes only while idle; read register holds its value while the beat stalls.
    always_ff @(posedge clk_int) begin
        if (wr_en && !tx_busy) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_reg <= mem[rd_addr];
        end
    end

    always_comb begin
        start_ok  = (state_reg == IDLE) && tx_start && (tx_len != '0);
        beat_fire = (state_reg == SEND) && tx_axis_tready;
        last_idx  = ((len_reg < PAD_MIN) ? PAD_MIN : len_reg) - 1'b1;
        is_last   = abort_beat_reg || (idx_reg == last_idx);
        abort_ok  = (state_reg == SEND) && tx_abort && !is_last;
        // Prefetch the byte after the presented one so a consumed beat is replaced next cycle.
        rd_en     = (state_reg == FETCH) || beat_fire;
        rd_addr   = (state_reg == FETCH) ? '0 : idx_reg[ADDR_WIDTH-1:0] + 1'b1;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start_ok) state_next = FETCH;
            FETCH:   state_next = SEND;
            SEND:    if (beat_fire && is_last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_int) begin
        if (rst_int) begin
            state_reg      <= IDLE;
            len_reg        <= '0;
            idx_reg        <= '0;
            abort_pend_reg <= 1'b0;
            abort_beat_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (start_ok) begin
                len_reg        <= (tx_len > MAX_LEN) ? MAX_LEN : tx_len;
                idx_reg        <= '0;
                abort_pend_reg <= 1'b0;
                abort_beat_reg <= 1'b0;
            end
            // An abort never disturbs the presented beat; it turns the following beat into the terminator.
            if (beat_fire) begin
                idx_reg        <= idx_reg + 1'b1;
                abort_beat_reg <= abort_beat_reg || abort_pend_reg || abort_ok;
                abort_pend_reg <= 1'b0;
            end else if (abort_ok) begin
                abort_pend_reg <= 1'b1;
            end
        end
    end

    always_comb begin
        tx_busy        = (state_reg != IDLE);
        tx_done        = (state_reg == DONE);
        tx_axis_tvalid = (state_reg == SEND);
        tx_axis_tlast  = (state_reg == SEND) && is_last;
        tx_axis_tuser  = (state_reg == SEND) && abort_beat_reg;
        tx_axis_tdata  = ((state_reg == SEND) && !abort_beat_reg && (idx_reg < len_reg))
                         ? rd_data_reg : 8'h00;
    end
endmodule

// File: tb/tb_tx_frame_streamer.sv
// Scoreboard bench for tx_frame_streamer: driver queues expected beats, negedge monitor checks them.
module tb_tx_frame_streamer;
    localparam int AW        = 11;
    localparam int DEPTH     = 1 << AW;
    localparam int MIN_FRAME = 60;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       user;
    } beat_t;

    logic          clk_int = 1'b0;
    logic          rst_int = 1'b1;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [7:0]    wr_data = '0;
    logic [AW:0]   tx_len = '0;
    logic          tx_start = 1'b0;
    logic          tx_abort = 1'b0;
    logic          tx_axis_tready = 1'b1;
    logic          tx_busy;
    logic          tx_done;
    logic [7:0]    tx_axis_tdata;
    logic          tx_axis_tvalid;
    logic          tx_axis_tlast;
    logic          tx_axis_tuser;

    tx_frame_streamer #(.ADDR_WIDTH(AW), .MIN_FRAME(MIN_FRAME)) dut (
        .clk_int(clk_int), .rst_int(rst_int),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .tx_len(tx_len), .tx_start(tx_start), .tx_abort(tx_abort),
        .tx_busy(tx_busy), .tx_done(tx_done),
        .tx_axis_tdata(tx_axis_tdata), .tx_axis_tvalid(tx_axis_tvalid),
        .tx_axis_tlast(tx_axis_tlast), .tx_axis_tuser(tx_axis_tuser),
        .tx_axis_tready(tx_axis_tready)
    );

    always #5 clk_int = ~clk_int;

    beat_t      sb_q[$];
    logic [7:0] model_mem [DEPTH];
    int         n_cmp = 0;
    int         n_err = 0;
    int         hs_count = 0;
    int         rmode = 0;
    bit         busy_m = 0, done_m = 0, send_m = 0, fetch_m = 0;
    bit         rst_prev = 0, stall_prev = 0;
    beat_t      prev_beat = '0;

    task automatic chk(input string name, input logic [9:0] got, input logic [9:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Monitor: models busy/valid/done timing from observed commands and pops expected beats.
    always @(negedge clk_int) begin : mon
        beat_t got;
        beat_t e;
        bit nb, nd, ns, nf;
        got = '{data: tx_axis_tdata, last: tx_axis_tlast, user: tx_axis_tuser};
        nb = busy_m; nd = 1'b0; ns = send_m; nf = 1'b0;
        chk("tx_busy", 10'(tx_busy), 10'(busy_m));
        chk("tx_done", 10'(tx_done), 10'(done_m));
        chk("tvalid", 10'(tx_axis_tvalid), 10'(send_m));
        if (rst_prev) chk("reset_outputs", 10'(got), 10'(0));
        if (stall_prev) chk("stall_hold", 10'(got), 10'(prev_beat));
        if (tx_axis_tvalid && tx_axis_tready) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_beat: got data=%h last=%b user=%b, expected no beat",
                         got.data, got.last, got.user);
            end else begin
                e = sb_q.pop_front();
                $display("beat %0d: data=%h last=%b user=%b (exp %h %b %b)",
                         hs_count, got.data, got.last, got.user, e.data, e.last, e.user);
                chk("beat", 10'(got), 10'(e));
                if (e.last) begin
                    ns = 1'b0;
                    nd = 1'b1;
                end
            end
            hs_count++;
        end
        if (done_m) nb = 1'b0;
        if (fetch_m) ns = 1'b1;
        if (!busy_m && tx_start && tx_len != '0 && !rst_int) begin
            nb = 1'b1;
            nf = 1'b1;
            hs_count = 0;
        end
        if (rst_int) begin
            nb = 1'b0; nd = 1'b0; ns = 1'b0; nf = 1'b0;
            sb_q.delete();
        end
        stall_prev = tx_axis_tvalid && !tx_axis_tready && !rst_int;
        prev_beat  = got;
        rst_prev   = rst_int;
        busy_m = nb; done_m = nd; send_m = ns; fetch_m = nf;
    end

    initial begin
        forever begin
            @(posedge clk_int);
            #1;
            case (rmode)
                0:       tx_axis_tready = 1'b1;
                1:       tx_axis_tready = ~tx_axis_tready;
                default: tx_axis_tready = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    task automatic tick();
        @(posedge clk_int);
        #1;
    endtask

    task automatic write_byte(input int a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
        model_mem[a] = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 20000 && tx_busy; i++) tick();
        if (tx_busy) begin
            $display("FAIL timeout_idle: tx_busy still 1 after %0d cycles, expected 0", i);
            $fatal(1, "timeout waiting for idle");
        end
    endtask

    task automatic wait_beat(input int k);
        int i;
        for (i = 0; i < 20000 && !(tx_axis_tvalid && hs_count == k); i++) tick();
        if (!(tx_axis_tvalid && hs_count == k)) begin
            $display("FAIL timeout_beat: beat %0d not presented (seen %0d), expected it", k, hs_count);
            $fatal(1, "timeout waiting for beat");
        end
    endtask

    // Reference frame: bytes 0..min(len,DEPTH)-1, zero padding if enabled, abort truncation.
    task automatic push_frame(input int len, input int abort_at);
        int n, total, nb;
        n = (len > DEPTH) ? DEPTH : len;
        total = n;
`ifdef TX_FRAME_STREAMER_PAD_EN
        if (total < MIN_FRAME) total = MIN_FRAME;
`endif
        nb = (abort_at >= 0 && abort_at < total - 1) ? abort_at + 1 : total;
        for (int i = 0; i < nb; i++)
            sb_q.push_back(beat_t'{data: (i < n) ? model_mem[i] : 8'h00, last: (i == total - 1), user: 1'b0});
        if (nb != total) sb_q.push_back(beat_t'{data: 8'h00, last: 1'b1, user: 1'b1});
    endtask

    task automatic send_frame(input int len, input int abort_at, input bit junk);
        push_frame(len, abort_at);
        tx_start = 1'b1; tx_len = (AW+1)'(len);
        tick();
        tx_start = 1'b0;
        if (junk) begin
            tx_abort = 1'b1; tx_start = 1'b1; tx_len = 5;
            wr_en = 1'b1; wr_addr = '0; wr_data = ~model_mem[0];
            tick();
            tx_abort = 1'b0; tx_start = 1'b0;
            for (int i = 1; i < 4; i++) begin
                wr_addr = AW'(i); wr_data = 8'($urandom);
                tick();
            end
            wr_en = 1'b0;
        end
        if (abort_at >= 0) begin
            wait_beat(abort_at);
            tx_abort = 1'b1;
            tick();
            tx_abort = 1'b0;
        end
        wait_idle();
        tick();
    endtask

    initial begin
        int len;
        int ab;
        // Start issued during reset must be ignored.
        rst_int = 1'b1; tx_start = 1'b1; tx_len = 10;
        repeat (3) tick();
        rst_int = 1'b0; tx_start = 1'b0;
        tick();
        for (int a = 0; a < DEPTH; a++) write_byte(a, 8'($urandom));
        for (int a = 0; a < 64; a++) write_byte(a, 8'(a));

        rmode = 0; send_frame(64, -1, 0);
        rmode = 1; send_frame(64, -1, 0);
        rmode = 0;
        for (int a = 0; a < 10; a++) write_byte(a, 8'(8'hA0 + a));
        send_frame(10, -1, 0);
        rmode = 2;
        send_frame(100, 20, 0);
        send_frame(30, 29, 0);
        send_frame(40, 0, 0);
        for (int a = 0; a < 10; a++) write_byte(a, 8'(a));

        // Reset mid-frame, with a simultaneous start that must be ignored.
        rmode = 0;
        push_frame(64, -1);
        tx_start = 1'b1; tx_len = 64;
        tick();
        tx_start = 1'b0;
        wait_beat(5);
        rst_int = 1'b1; tx_start = 1'b1;
        tick();
        rst_int = 1'b0; tx_start = 1'b0;
        repeat (3) tick();
        send_frame(64, -1, 0);

        tx_start = 1'b1; tx_len = 0;
        tick();
        tx_start = 1'b0;
        repeat (5) tick();

        rmode = 2;
        send_frame(64, -1, 1);
        send_frame(64, -1, 0);

        for (int f = 0; f < 6; f++) begin
            for (int w = 0; w < 8; w++) write_byte(int'($urandom_range(0, 255)), 8'($urandom));
            len = int'($urandom_range(1, 200));
            ab = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, len - 1)) : -1;
            send_frame(len, ab, 0);
        end

        send_frame(DEPTH + 5, -1, 0);
        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/tx_frame_streamer.md
TX_FRAME_STREAMER -- requirements
Module: tx_frame_streamer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 11, byte-address width of the frame buffer (depth 2**ADDR_WIDTH).
REQ-002 SHALL have parameter MIN_FRAME, default 60, minimum emitted frame length in bytes (pre-FCS), used only when padding is enabled.
REQ-003 SHALL have port clk_int  input  1  sole clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_int  input  1  reset, synchronous and active-high.
REQ-005 SHALL have ports wr_en / wr_addr / wr_data  input  1 / ADDR_WIDTH / 8  buffer byte-write port.
REQ-006 SHALL have port tx_len  input  ADDR_WIDTH+1  frame length in bytes, sampled on tx_start.
REQ-007 SHALL have ports tx_start / tx_abort  input  1 / 1  single-cycle command strobes.
REQ-008 SHALL have ports tx_busy / tx_done  output  1 / 1  frame in progress / one-cycle completion pulse.
REQ-009 SHALL have ports tx_axis_tdata / tvalid / tlast / tuser  output  8/1/1/1  AXI-stream source toward the MAC.
REQ-010 SHALL have port tx_axis_tready  input  1  MAC backpressure.

Function
REQ-011 SHALL store wr_data at wr_addr on a cycle with wr_en=1 and tx_busy=0; writes while tx_busy=1 SHALL be dropped.
REQ-012 SHALL implement states IDLE, FETCH, SEND, DONE.
REQ-013 IDLE: tx_start=1 with tx_len>0 SHALL latch the length, set tx_busy=1 and enter FETCH next cycle; tx_start with tx_len=0 SHALL be ignored (no tx_done).
REQ-014 tx_len greater than 2**ADDR_WIDTH SHALL be clamped to 2**ADDR_WIDTH.
REQ-015 FETCH SHALL issue a synchronous read of address 0 and enter SEND; tx_axis_tvalid SHALL first assert exactly 2 cycles after the tx_start cycle.
REQ-016 SEND: each beat SHALL hold tdata/tlast/tuser stable while tvalid=1 and tready=0; a beat completes only when tvalid=1 and tready=1.
REQ-017 SEND SHALL prefetch so that with tready held at 1 one byte is transferred every cycle, with no bubbles.
REQ-018 Byte index i SHALL carry buffer[i]; tlast SHALL be 1 only on the final beat (index len-1, or the padded end per REQ-030).
REQ-019 After the final beat completes, the FSM SHALL enter DONE for one cycle: tx_done=1, tvalid=0; next cycle IDLE with tx_busy=0.
REQ-020 tx_start while tx_busy=1 SHALL be ignored.
REQ-021 tx_abort in SEND SHALL leave any currently presented beat unchanged; the next emitted beat SHALL be the final beat, with tlast=1, tuser=1 and tdata=0x00.
REQ-022 tx_abort SHALL be ignored if the presented beat already has tlast=1, and in IDLE, FETCH or DONE.
REQ-023 tx_axis_tuser SHALL be 0 on all non-aborted frames.
REQ-024 The byte counter SHALL be ADDR_WIDTH+1 bits and SHALL not wrap within a frame; a 2**ADDR_WIDTH-byte frame ends at address 2**ADDR_WIDTH-1.

Reset
REQ-025 While rst_int=1: state IDLE; tx_busy, tx_done, tx_axis_tvalid, tlast, tuser = 0; tdata = 0x00.
REQ-026 Reset asserted mid-frame SHALL drop tvalid on the following cycle, with no tlast and no tx_done; buffer contents are not cleared.
REQ-027 Commands in the same cycle as rst_int=1 SHALL be ignored.

Configuration
REQ-028 Macro TX_FRAME_STREAMER_PAD_EN SHALL select minimum-length padding.
REQ-029 Without the macro, exactly min(tx_len, 2**ADDR_WIDTH) beats SHALL be emitted, and MIN_FRAME is unused.
REQ-030 With the macro, when latched len < MIN_FRAME, beats len..MIN_FRAME-1 SHALL carry 0x00, and tlast SHALL be on beat MIN_FRAME-1; an abort SHALL still terminate per REQ-021.

Verification
REQ-031 Write 0x00..0x3F to addresses 0..63, tx_len=64, tready=1 -> 64 beats 0x00..0x3F on consecutive cycles; tlast on 0x3F; tvalid 2 cycles after tx_start; tx_done 1 cycle after the last beat.
REQ-032 Same frame, tready toggled 1/0 every cycle -> identical byte sequence; data held stable during stalls; 64 handshakes.
REQ-033 tx_len=10 with bytes 0xA0..0xA9 -> with PAD_EN: 60 beats, beats 10..59 = 0x00, tlast on beat 59; without PAD_EN: 10 beats, tlast on 0xA9.
REQ-034 tx_len=100, tx_abort after beat 20 completes -> beat 21 = 0x00 with tlast=1, tuser=1, then tx_done.
REQ-035 rst_int pulsed at beat 5 of a 64-byte frame -> tvalid=0 next cycle, no tx_done; a new tx_start then sends the frame from byte 0.
REQ-036 tx_start while busy, and tx_start with tx_len=0 -> both ignored; wr_en during busy leaves buffer unchanged (verified by resend).
